// File: rtl/burst_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_link_pkg : shared state encoding and defaults for burst link   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package burst_link_pkg;

  localparam int DEF_DW      = 16;
  localparam int DEF_AW      = 12;
  localparam int DEF_DEPTH   = 1 << DEF_AW;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RECV = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/burst_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_buf : DEPTH x DW single-port buffer, registered read data      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module burst_buf
  import burst_link_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read register returns zero when idle so it can drive tx_data directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/burst_link_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_link_initiator : collect burst, replay to core, forward reply  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module burst_link_initiator
  import burst_link_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic          err_len,
  output logic          err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [AW:0]   r_wcnt, w_wcnt_nxt, w_wcnt_inc;
  logic [AW:0]   r_rcnt, w_rcnt_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_s_ready, w_s_ready_nxt;
  logic          r_tx_valid;
  logic          r_m_valid, w_m_valid_nxt;
  logic [DW-1:0] r_m_data, w_m_data_nxt;
  logic          r_m_last, w_m_last_nxt;
  logic          r_busy, r_done;
  logic          r_err_len, w_err_len_nxt;
  logic          r_err_timeout, w_err_timeout_nxt;
  logic          w_hs, w_wr_en, w_rd_en;
  logic [AW-1:0] w_buf_addr;
  logic [DW-1:0] w_buf_rdata;

  assign w_hs       = s_valid & r_s_ready;
  assign w_wcnt_inc = r_wcnt + 1'b1;
  // Writes and reads never overlap, so one address port suffices.
  assign w_buf_addr = w_wr_en ? r_wcnt[AW-1:0] : r_rcnt[AW-1:0];

  burst_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_wr_en),
    .re    (w_rd_en),
    .addr  (w_buf_addr),
    .wdata (s_data),
    .rdata (w_buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_rcnt        <= '0;
      r_timer       <= '0;
      r_s_ready     <= 1'b1;
      r_tx_valid    <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_m_last      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_rcnt        <= w_rcnt_nxt;
      r_timer       <= w_timer_nxt;
      r_s_ready     <= w_s_ready_nxt;
      r_tx_valid    <= w_rd_en;
      r_m_valid     <= w_m_valid_nxt;
      r_m_data      <= w_m_data_nxt;
      r_m_last      <= w_m_last_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_done        <= (w_state_nxt == ST_DONE);
      r_err_len     <= w_err_len_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wcnt_nxt        = r_wcnt;
    w_rcnt_nxt        = r_rcnt;
    w_timer_nxt       = r_timer;
    w_err_len_nxt     = r_err_len;
    w_err_timeout_nxt = r_err_timeout;
    w_wr_en           = 1'b0;
    w_rd_en           = 1'b0;
    w_m_valid_nxt     = 1'b0;
    w_m_data_nxt      = '0;
    w_m_last_nxt      = 1'b0;

    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_hs) begin
          w_wr_en    = 1'b1;
          w_wcnt_nxt = w_wcnt_inc;
          if (r_state == ST_IDLE) begin
            w_err_len_nxt     = 1'b0;
            w_err_timeout_nxt = 1'b0;
          end
          if (s_last || (w_wcnt_inc == c_depth)) begin
            w_state_nxt = ST_SEND;
            w_rcnt_nxt  = '0;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
      end

      // rcnt is the read index here; data appears one cycle after the address.
      ST_SEND: begin
        w_rd_en    = 1'b1;
        w_rcnt_nxt = r_rcnt + 1'b1;
        if (r_rcnt == (r_wcnt - 1'b1)) begin
          w_state_nxt = ST_WAIT;
          w_rcnt_nxt  = '0;
          w_timer_nxt = '0;
        end
      end

      ST_WAIT: begin
        if (rx_valid) begin
          w_state_nxt   = ST_RECV;
          w_m_valid_nxt = 1'b1;
          w_m_data_nxt  = rx_data;
          w_m_last_nxt  = (r_wcnt == {{AW{1'b0}}, 1'b1});
          w_rcnt_nxt    = {{AW{1'b0}}, 1'b1};
        end else if (!r_tx_valid) begin
          if (r_timer == c_tmo_last) begin
            w_err_timeout_nxt = 1'b1;
            w_state_nxt       = ST_DONE;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
      end

      ST_RECV: begin
        if (rx_valid) begin
          if (r_rcnt < r_wcnt) begin
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = rx_data;
            w_m_last_nxt  = (r_rcnt == (r_wcnt - 1'b1));
            w_rcnt_nxt    = r_rcnt + 1'b1;
          end else begin
            w_err_len_nxt = 1'b1;
          end
        end else begin
          if (r_rcnt < r_wcnt) begin
            w_err_len_nxt = 1'b1;
          end
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = '0;
        w_rcnt_nxt  = '0;
        w_timer_nxt = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = '0;
        w_rcnt_nxt  = '0;
        w_timer_nxt = '0;
      end
    endcase

    w_s_ready_nxt = ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FILL)) &&
                    (w_wcnt_nxt < c_depth);
  end

  assign s_ready     = r_s_ready;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = w_buf_rdata;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_burst_link_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_burst_link_initiator : directed scoreboard bench, small DEPTH/TMO |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_burst_link_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy, done, err_len, err_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = 0;
  int fall_cyc = 0;
  int m_seen = 0;
  int m_base = 0;
  int dcyc = 0;
  int t = 0;
  bit mon_en = 1'b0;

  logic [15:0] tx_exp[$];
  logic [16:0] m_exp[$];
  logic [15:0] sent_q[$];
  logic [15:0] tx_e;
  logic [16:0] m_e;

  burst_link_initiator #(
    .DW(16), .DEPTH(8), .AW(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tx scoreboard: every burst word must match the next accepted upstream word
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid === 1'b1) begin
        if (tx_exp.size() == 0) check("tx_unexpected", {31'd0, tx_valid}, 32'd0);
        else begin
          tx_e = tx_exp.pop_front();
          check("tx_data", {16'd0, tx_data}, {16'd0, tx_e});
        end
      end else begin
        check("tx_data_idle", {16'd0, tx_data}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && m_valid === 1'b1) begin
      m_seen++;
      if (m_exp.size() == 0) check("m_unexpected", {31'd0, m_valid}, 32'd0);
      else begin
        m_e = m_exp.pop_front();
        check("m_data", {16'd0, m_data}, {16'd0, m_e[15:0]});
        check("m_last", {31'd0, m_last}, {31'd0, m_e[16]});
      end
    end
  end

  task automatic send_burst(input int n, input bit with_last, input int base, input int step);
    bit stalled;
    stalled = 1'b0;
    sent_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b1) begin
        stalled = 1'b1;
        break;
      end
      s_valid = 1'b1;
      s_data  = 16'(base + i * step);
      s_last  = with_last && (i == n - 1);
      sent_q.push_back(s_data);
      tx_exp.push_back(s_data);
      last_hs = cyc;
    end
    if (!stalled) @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic run_tx(input int len_exp);
    int tt;
    int len;
    tt = 0;
    while (tx_valid !== 1'b1 && tt < 32) begin @(negedge clk); tt++; end
    check("tx_start", {31'd0, tx_valid}, 32'd1);
    check("tx_latency", cyc - last_hs, 32'd2);
    len = 0;
    while (tx_valid === 1'b1 && len < 64) begin len++; @(negedge clk); end
    check("tx_len", len, len_exp);
    fall_cyc = cyc;
  endtask

  // Core model: answers k words starting two cycles after tx_valid falls.
  task automatic respond(input int k, input int len);
    m_base = m_seen;
    repeat (2) @(negedge clk);
    for (int j = 0; j < k; j++) begin
      rx_valid = 1'b1;
      rx_data  = (j < sent_q.size()) ? sent_q[j] : 16'(16'hEE00 + j);
      if (j < len) m_exp.push_back({(j == len - 1), rx_data});
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic finish_txn(input string tag, input bit e_len, input bit e_to, input int m_cnt);
    int tt;
    tt = 0;
    while (done !== 1'b1 && tt < 64) begin @(negedge clk); tt++; end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    dcyc = cyc;
    check({tag, "_err_len"}, {31'd0, err_len}, {31'd0, e_len});
    check({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, e_to});
    check({tag, "_m_count"}, m_seen - m_base, m_cnt);
    check({tag, "_m_pending"}, m_exp.size(), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_s_ready_idle"}, {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_errs", {30'd0, err_len, err_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three words, loopback echo
    send_burst(3, 1'b1, 16'h1111, 16'h1111);
    check("t1_busy", {31'd0, busy}, 32'd1);
    run_tx(3);
    respond(3, 3);
    finish_txn("t1", 1'b0, 1'b0, 3);

    // 2: ten words with no last; only DEPTH=8 accepted
    send_burst(10, 1'b0, 16'h0100, 1);
    check("t2_accepted", sent_q.size(), 32'd8);
    check("t2_s_ready_full", {31'd0, s_ready}, 32'd0);
    run_tx(8);
    respond(8, 8);
    finish_txn("t2", 1'b0, 1'b0, 8);

    // 3: short response
    send_burst(4, 1'b1, 16'hA000, 16'h0011);
    run_tx(4);
    respond(2, 4);
    finish_txn("t3", 1'b1, 1'b0, 2);

    // 4: long response, extra word dropped
    send_burst(2, 1'b1, 16'hB000, 16'h0101);
    run_tx(2);
    respond(3, 2);
    finish_txn("t4", 1'b1, 1'b0, 2);

    // 5: no response -> timeout 16 cycles after tx_valid falls
    send_burst(3, 1'b1, 16'hC000, 16'h0003);
    run_tx(3);
    m_base = m_seen;
    finish_txn("t5", 1'b0, 1'b1, 0);
    check("t5_timeout_latency", dcyc - fall_cyc, 32'd16);

    // 6: reset in the middle of a tx burst
    send_burst(5, 1'b1, 16'hD000, 16'h0010);
    check("t6_err_timeout_cleared", {31'd0, err_timeout}, 32'd0);
    t = 0;
    while (tx_valid !== 1'b1 && t < 32) begin @(negedge clk); t++; end
    check("t6_tx_start", {31'd0, tx_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_tx_valid_rst", {31'd0, tx_valid}, 32'd0);
    check("t6_busy_rst", {31'd0, busy}, 32'd0);
    check("t6_s_ready_rst", {31'd0, s_ready}, 32'd1);
    rst_n = 1'b1;
    tx_exp.delete();
    m_exp.delete();
    repeat (3) @(negedge clk);
    check("t6_tx_quiet", {31'd0, tx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
